// File: rtl/enable_tick_monitor_pkg.sv
// Shared types and helpers for tick-strobe consumers: monitor FSM states and width helper.
package enable_tick_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } mon_state_e;

  // Smallest b such that 2**b >= n; usable in constant expressions.
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Saturating cycle counter between strobes; provides the running interval and a timeout flag.
module tick_interval_counter #(
  parameter int unsigned Timeout = 20,
  parameter int unsigned CntBits = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_en_i,
  input  logic               armed_i,
  output logic [CntBits-1:0] interval_o,
  output logic               timeout_o
);

  localparam logic [CntBits-1:0] TimeoutW   = CntBits'(Timeout);
  localparam logic [CntBits-1:0] TimeoutM1W = CntBits'(Timeout - 1);

  logic [CntBits-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_en_i) begin
      cnt_d = '0;
    end else if (cnt_q != TimeoutW) begin
      cnt_d = cnt_q + CntBits'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // While armed the count never exceeds Timeout-1, so this cannot wrap.
  assign interval_o = cnt_q + CntBits'(1);
  assign timeout_o  = armed_i & ~in_en_i & (cnt_q == TimeoutM1W);

endmodule

// File: rtl/enable_tick_monitor.sv
// Lock/health monitor for a periodic single-cycle enable strobe: measures the strobe
// interval, flags short/long/missing strobes and declares lock after consecutive good intervals.
module enable_tick_monitor
  import enable_tick_monitor_pkg::*;
#(
  parameter int unsigned ClkFreq      = 100000000,
  parameter int unsigned EnFreq       = 1000,
  parameter int unsigned MaxErrorPerc = 10,
  parameter int unsigned LockCount    = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          in_en_i,
  output logic [ceil_log2(2*(ClkFreq/EnFreq)+1)-1:0]    period_o,
  output logic                                          period_valid_o,
  output logic                                          locked_o,
  output logic                                          err_short_o,
  output logic                                          err_long_o,
  output logic                                          err_timeout_o
);

  localparam int unsigned Nominal  = ClkFreq / EnFreq;
  localparam int unsigned Tol      = Nominal * MaxErrorPerc / 100;
  localparam int unsigned MinP     = Nominal - Tol;
  localparam int unsigned MaxP     = Nominal + Tol;
  localparam int unsigned Timeout  = 2 * Nominal;
  localparam int unsigned CntBits  = ceil_log2(Timeout + 1);
  localparam int unsigned GoodBits = ceil_log2(LockCount + 1);

  localparam logic [CntBits-1:0]  MinPw    = CntBits'(MinP);
  localparam logic [CntBits-1:0]  MaxPw    = CntBits'(MaxP);
  localparam logic [GoodBits-1:0] LockLast = GoodBits'(LockCount - 1);

  if ((ClkFreq / 2 < EnFreq) || (Nominal < Tol + 2) || (LockCount < 1)) begin : gen_drc_fail
    $error("enable_tick_monitor: illegal parameter combination");
  end

  mon_state_e          state_q, state_d;
  logic [GoodBits-1:0] good_q, good_d;
  logic [CntBits-1:0]  period_q, period_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic                timeout_q, timeout_d;

  logic [CntBits-1:0]  interval;
  logic                timeout_hit;
  logic                armed;
  logic                in_range;
  logic                too_short;

  assign armed = (state_q != StIdle);

  tick_interval_counter #(
    .Timeout (Timeout),
    .CntBits (CntBits)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_en_i    (in_en_i),
    .armed_i    (armed),
    .interval_o (interval),
    .timeout_o  (timeout_hit)
  );

  assign too_short = (interval < MinPw);
  assign in_range  = !too_short && (interval <= MaxPw);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    short_d   = 1'b0;
    long_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        good_d = '0;
        if (in_en_i) begin
          state_d = StAcq;
        end
      end
      StAcq, StLocked: begin
        if (in_en_i) begin
          period_d = interval;
          valid_d  = 1'b1;
          if (in_range) begin
            if (state_q == StAcq) begin
              if (good_q == LockLast) begin
                state_d  = StLocked;
                locked_d = 1'b1;
                good_d   = '0;
              end else begin
                good_d = good_q + GoodBits'(1);
              end
            end
          end else begin
            // A bad interval restarts acquisition; the strobe itself becomes the new reference.
            state_d  = StAcq;
            good_d   = '0;
            locked_d = 1'b0;
            short_d  = too_short;
            long_d   = !too_short;
          end
        end else if (timeout_hit) begin
          state_d   = StIdle;
          good_d    = '0;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        good_d   = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      good_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      short_q   <= short_d;
      long_q    <= long_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign err_short_o    = short_q;
  assign err_long_o     = long_q;
  assign err_timeout_o  = timeout_q;

endmodule
